// File: rtl/adq_if.sv
// ADC acquisition bus: request/conversion inputs toward the sequencer and its
// state, address and memory-read outputs back to the controller.
interface adq_if #(
    parameter int DATA_W = 32,
    parameter int ADD_S  = 8
);
    logic              init;
    logic              eoc;
    logic [DATA_W-1:0] data_in;
    logic [6:0]        present_state;
    logic [ADD_S-1:0]  count;
    logic              fac;
    logic [DATA_W-1:0] data_out;

    modport master (
        output init, eoc, data_in,
        input  present_state, count, fac, data_out
    );

    modport slave (
        input  init, eoc, data_in,
        output present_state, count, fac, data_out
    );
endinterface

// File: rtl/adq_acquisition_system.sv
// ADC acquisition sequencer: on init, stores one sample per end-of-conversion
// into a 2**ADD_S word memory at a saturating address counter, then signals ACK.
module adq_acquisition_system #(
    parameter int DATA_W = 32,
    parameter int ADD_S  = 8
) (
    input  logic clk,
    input  logic rst,
    adq_if.slave bus
);
    localparam int DEPTH = 2 ** ADD_S;

    // Bit positions inside present_state = {ACK, W, CS, SC, CC, RC, WFC}
    localparam int F_ACK = 6;
    localparam int F_W   = 5;
    localparam int F_CS  = 4;
    localparam int F_SC  = 3;
    localparam int F_CC  = 2;
    localparam int F_RC  = 1;
    localparam int F_WFC = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_CNT,
        S_START,
        S_WAIT,
        S_WRITE,
        S_INC,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADD_S-1:0]  count_q, count_d;
    logic              wr_en;
    logic              fac;
    logic [6:0]        flags;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // The counter never wraps: INC only increments while it is below full.
    assign fac = (count_q == {ADD_S{1'b1}});

    // NOTE: every variable gets a default at the top of always_comb so that no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        flags   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.init) state_d = S_RST_CNT;
            end
            S_RST_CNT: begin
                flags[F_RC] = 1'b1;
                count_d     = '0;
                state_d     = S_START;
            end
            S_START: begin
                flags[F_SC] = 1'b1;
                flags[F_CS] = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                flags[F_WFC] = 1'b1;
                flags[F_CS]  = 1'b1;
                if (bus.eoc) state_d = S_WRITE;
            end
            S_WRITE: begin
                flags[F_W]  = 1'b1;
                flags[F_CS] = 1'b1;
                wr_en       = 1'b1;
                state_d     = S_INC;
            end
            S_INC: begin
                flags[F_CC] = 1'b1;
                if (fac) begin
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = S_START;
                end
            end
            S_DONE: begin
                flags[F_ACK] = 1'b1;
                if (bus.init) state_d = S_RST_CNT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: the memory is deliberately reset word by word; an aborted run must
    // leave no stale samples visible on data_out, so this cannot map to SRAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[count_q] <= bus.data_in;
        end
    end

    assign bus.present_state = flags;
    assign bus.count         = count_q;
    assign bus.fac           = fac;
    assign bus.data_out      = mem_q[count_q];
endmodule

// File: tb/tb_adq_acquisition_system.sv
// Self-checking bench for adq_acquisition_system: reset, a cycle-by-cycle
// vector table, a 257-pulse scoreboarded run, mid-run reset and restart.
module tb_adq_acquisition_system;
    localparam logic [6:0] S_IDLE = 7'b0000000;
    localparam logic [6:0] S_RC   = 7'b0000010;
    localparam logic [6:0] S_ST   = 7'b0011000;
    localparam logic [6:0] S_WT   = 7'b0010001;
    localparam logic [6:0] S_WR   = 7'b0110000;
    localparam logic [6:0] S_INC  = 7'b0000100;
    localparam logic [6:0] S_DONE = 7'b1000000;

    typedef struct {
        logic        init;
        logic        eoc;
        logic [31:0] din;
        logic [6:0]  st;
        logic [7:0]  cnt;
        logic [31:0] dout;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } sb_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t tbl[14];
    sb_t  sb_q[$];

    adq_if #(.DATA_W(32), .ADD_S(8)) bus ();

    adq_acquisition_system #(.DATA_W(32), .ADD_S(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, bus.present_state, S_IDLE);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_dout"}, bus.data_out, 0);
    endtask

    // Pop the oldest expected write and compare it with what the DUT shows in INC.
    task automatic sb_pop(input string tag);
        sb_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_addr"}, bus.count, e.addr);
            check({tag, "_data"}, bus.data_out, e.data);
        end
    endtask

    // From WAIT: one eoc pulse, then back to WAIT at the next address.
    task automatic do_sample(input logic [31:0] d);
        bus.eoc     = 1'b1;
        bus.data_in = d;
        step();
        bus.eoc = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b0;
        bus.init    = 1'b0;
        bus.eoc     = 1'b0;
        bus.data_in = '0;

        // Reset state, then 20 idle cycles with no init
        #2;
        check_idle("rst");
        check("rst_fac", bus.fac, 0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_idle("idle20");
        end

        // Cycle-by-cycle vectors: ignored eoc/init, held eoc, closing-edge data capture
        tbl[0]  = '{1'b0, 1'b1, 32'h0,         S_IDLE, 8'd0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,         S_RC,   8'd0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 32'h0,         S_ST,   8'd0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,         S_WT,   8'd0, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,         S_WT,   8'd0, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_DEAD, S_WR,   8'd0, 32'h0};
        tbl[6]  = '{1'b1, 1'b1, 32'h0000_00A0, S_INC,  8'd0, 32'h0000_00A0};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_0BAD, S_ST,   8'd1, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_0BAD, S_WT,   8'd1, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 32'h0000_00B1, S_WR,   8'd1, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_00B1, S_INC,  8'd1, 32'h0000_00B1};
        tbl[11] = '{1'b0, 1'b1, 32'h0,         S_ST,   8'd2, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 32'h0,         S_WT,   8'd2, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,         S_WT,   8'd2, 32'h0};
        for (int i = 0; i < 14; i++) begin
            bus.init    = tbl[i].init;
            bus.eoc     = tbl[i].eoc;
            bus.data_in = tbl[i].din;
            step();
            check($sformatf("vec%0d_state", i), bus.present_state, tbl[i].st);
            check($sformatf("vec%0d_count", i), bus.count, tbl[i].cnt);
            check($sformatf("vec%0d_dout", i), bus.data_out, tbl[i].dout);
            check($sformatf("vec%0d_fac", i), bus.fac, 0);
        end
        bus.init = 1'b0;
        bus.eoc  = 1'b0;

        // Advance to count 10 in WAIT, then reset asynchronously mid-run
        for (int k = 2; k < 10; k++) do_sample(32'hC000_0000 + k);
        check("pre_abort_state", bus.present_state, S_WT);
        check("pre_abort_count", bus.count, 10);
        #3 rst = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_fac", bus.fac, 0);
        step();
        check_idle("rst_held");
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("post_abort");
        end

        // Full run: 257 eoc pulses every 14 cycles, data = 0xFFFFFFFF - j
        bus.init = 1'b1;
        step();
        check("run_rc", bus.present_state, S_RC);
        bus.init = 1'b0;
        step();
        check("run_st0", bus.present_state, S_ST);
        check("run_st0_count", bus.count, 0);
        step();
        for (int k = 0; k < 256; k++) begin
            check($sformatf("s%0d_wait", k), bus.present_state, S_WT);
            check($sformatf("s%0d_count", k), bus.count, k);
            check($sformatf("s%0d_cleared", k), bus.data_out, 0);
            check($sformatf("s%0d_fac", k), bus.fac, (k == 255));
            repeat (10) step();
            check($sformatf("s%0d_still_wait", k), bus.present_state, S_WT);
            bus.eoc     = 1'b1;
            bus.data_in = 32'hFFFF_FFFF - k;
            sb_q.push_back('{addr: k[7:0], data: 32'hFFFF_FFFF - k});
            step();
            check($sformatf("s%0d_write", k), bus.present_state, S_WR);
            bus.eoc = 1'b0;
            step();
            check($sformatf("s%0d_inc", k), bus.present_state, S_INC);
            sb_pop($sformatf("s%0d", k));
            step();
            if (k < 255) begin
                check($sformatf("s%0d_next_st", k), bus.present_state, S_ST);
                check($sformatf("s%0d_next_count", k), bus.count, k + 1);
                step();
            end else begin
                check("done_state", bus.present_state, S_DONE);
                check("done_count", bus.count, 255);
                check("done_fac", bus.fac, 1);
                check("done_mem255", bus.data_out, 32'hFFFF_FF00);
            end
        end

        // 257th eoc while in DONE: ignored
        bus.eoc     = 1'b1;
        bus.data_in = 32'h5555_5555;
        step();
        bus.eoc = 1'b0;
        step();
        check("eoc257_state", bus.present_state, S_DONE);
        check("eoc257_count", bus.count, 255);
        check("eoc257_mem255", bus.data_out, 32'hFFFF_FF00);
        check("sb_drained", sb_q.size(), 0);

        // Restart from DONE: counter back to 0, next write lands at address 0
        bus.init = 1'b1;
        step();
        check("restart_rc", bus.present_state, S_RC);
        bus.init = 1'b0;
        step();
        check("restart_st", bus.present_state, S_ST);
        check("restart_count", bus.count, 0);
        check("restart_old_mem0", bus.data_out, 32'hFFFF_FFFF);
        step();
        bus.eoc     = 1'b1;
        bus.data_in = 32'h1234_5678;
        sb_q.push_back('{addr: 8'd0, data: 32'h1234_5678});
        step();
        check("restart_write", bus.present_state, S_WR);
        bus.eoc = 1'b0;
        step();
        check("restart_inc", bus.present_state, S_INC);
        sb_pop("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
